// File: rtl/zion_seg_pack_reg.sv
// zion_seg_pack_reg: accumulates addressed sub-word segments into a full word and presents it on valid/ready
module zion_seg_pack_reg #(
    parameter int WIDTH_ADDR     = 2,
    parameter int WIDTH_DATA_IN  = 8,
    parameter int WIDTH_DATA_OUT = 32,
    parameter bit CHECK_ERR_EXIT = 1'b0,
    localparam int NUM_SEG       = WIDTH_DATA_OUT / WIDTH_DATA_IN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iVld,
    output logic                      oRdy,
    input  logic [WIDTH_ADDR-1:0]     iAddr,
    input  logic [WIDTH_DATA_IN-1:0]  iDat,
    input  logic                      iFlush,
    output logic                      oVld,
    input  logic                      iRdy,
    output logic [WIDTH_DATA_OUT-1:0] oDat,
    output logic [NUM_SEG-1:0]        oMask,
    output logic                      oErr
);
    generate
        if ((WIDTH_DATA_OUT % WIDTH_DATA_IN != 0) || (NUM_SEG > 2 ** WIDTH_ADDR)) begin : g_bad_cfg
            if (CHECK_ERR_EXIT) begin : g_exit
                $fatal(1, "zion_seg_pack_reg: illegal width configuration");
            end else begin : g_warn
                $error("zion_seg_pack_reg: illegal width configuration");
            end
        end
    endgenerate

    typedef enum logic {FILL, HOLD} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [WIDTH_DATA_OUT-1:0] r_dat;
    logic [NUM_SEG-1:0]        r_mask;
    logic                      r_err;
    logic                      w_acc;
    logic                      w_in_rng;
    logic [NUM_SEG-1:0]        w_hot;
    logic [NUM_SEG-1:0]        w_mask_nx;

    // the extra top bit keeps the compare correct when NUM_SEG equals 2**WIDTH_ADDR
    assign w_in_rng  = {1'b0, iAddr} < (WIDTH_ADDR + 1)'(NUM_SEG);
    assign oRdy      = (r_state == FILL) && !rst;
    assign oVld      = (r_state == HOLD);
    assign w_acc     = iVld && oRdy;
    assign w_hot     = w_in_rng ? (NUM_SEG'(1) << iAddr) : '0;
    assign w_mask_nx = r_mask | w_hot;
    assign oDat      = r_dat;
    assign oMask     = r_mask;
    assign oErr      = r_err;

    // next state: complete word or non-empty flush moves to HOLD, downstream ready returns to FILL
    always_comb begin
        w_next = r_state;
        if (r_state == FILL && w_acc && ((&w_mask_nx) || (iFlush && (|w_mask_nx))))
            w_next = HOLD;
        else if (r_state == HOLD && iRdy)
            w_next = FILL;
    end

    // state, segment storage, write mask and out-of-range error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_dat   <= '1;
            r_mask  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_acc && !w_in_rng;
            if (r_state == HOLD && iRdy) begin
                r_dat  <= '1;
                r_mask <= '0;
            end else if (w_acc) begin
                r_mask <= w_mask_nx;
                for (int i = 0; i < NUM_SEG; i++)
                    if (w_hot[i]) r_dat[i*WIDTH_DATA_IN +: WIDTH_DATA_IN] <= iDat;
            end
        end
    end
endmodule

// File: tb/tb_zion_seg_pack_reg.sv
// tb_zion_seg_pack_reg: directed and random checks of the segment packer against a word-level model
module tb_zion_seg_pack_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iVld = 1'b0;
    logic        oRdy;
    logic [2:0]  iAddr = '0;
    logic [7:0]  iDat = '0;
    logic        iFlush = 1'b0;
    logic        oVld;
    logic        iRdy = 1'b0;
    logic [31:0] oDat;
    logic [3:0]  oMask;
    logic        oErr;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_seg [4];
    logic [3:0] m_mask;
    bit         m_hold;
    bit         m_err;

    zion_seg_pack_reg #(.WIDTH_ADDR(3), .WIDTH_DATA_IN(8), .WIDTH_DATA_OUT(32)) dut (
        .clk(clk), .rst(rst), .iVld(iVld), .oRdy(oRdy), .iAddr(iAddr), .iDat(iDat),
        .iFlush(iFlush), .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oMask(oMask), .oErr(oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word();
        return {m_seg[3], m_seg[2], m_seg[1], m_seg[0]};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_seg[i] = 8'hFF;
        m_mask = '0;
    endtask

    // one clock: drive, compare every output with the model, advance the model, clock
    task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d,
                        input logic f, input logic r, input logic rs);
        bit acc;
        iVld = v; iAddr = a; iDat = d; iFlush = f; iRdy = r; rst = rs;
        #1;
        check("oRdy", 32'(oRdy), 32'(!m_hold && !rs));
        check("oVld", 32'(oVld), 32'(m_hold));
        check("oDat", oDat, m_word());
        check("oMask", 32'(oMask), 32'(m_mask));
        check("oErr", 32'(oErr), 32'(m_err));
        acc = v && !m_hold && !rs;
        if (rs) begin
            m_hold = 0; m_err = 0; m_clear();
        end else begin
            m_err = acc && a >= 4;
            if (m_hold) begin
                if (r) begin m_hold = 0; m_clear(); end
            end else if (acc) begin
                if (a < 4) begin m_seg[a] = d; m_mask[a] = 1'b1; end
                if (m_mask == 4'hF || (f && m_mask != 0)) m_hold = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] a, input logic [7:0] d, input logic f, input logic r);
        step(1'b1, a, d, f, r, 1'b0);
    endtask

    task automatic idle(input logic r);
        step(1'b0, 3'd0, 8'd0, 1'b0, r, 1'b0);
    endtask

    initial begin
        m_hold = 0; m_err = 0; m_clear();
        @(posedge clk); #1;
        step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        // in-order word
        beat(3'd0, 8'h11, 0, 1); beat(3'd1, 8'h22, 0, 1); beat(3'd2, 8'h33, 0, 1);
        check("seq_no_vld_before", 32'(oVld), 32'd0);
        beat(3'd3, 8'h44, 0, 1);
        check("seq_vld", 32'(oVld), 32'd1);
        check("seq_dat", oDat, 32'h44332211);
        check("seq_mask", 32'(oMask), 32'hF);
        idle(1);
        check("seq_rdy_back", 32'(oRdy), 32'd1);
        check("seq_mask_clr", 32'(oMask), 32'd0);
        // out-of-order with backpressure; beats during HOLD ignored
        beat(3'd2, 8'hA2, 0, 0); beat(3'd0, 8'hA0, 0, 0); beat(3'd3, 8'hA3, 0, 0); beat(3'd1, 8'hA1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            beat(3'd0, 8'h55, 0, 0);
            check("ooo_hold_dat", oDat, 32'hA3A2A1A0);
            check("ooo_hold_rdy", 32'(oRdy), 32'd0);
        end
        idle(1);
        // flush with a write
        beat(3'd1, 8'h5A, 1, 0);
        check("flush_dat", oDat, 32'hFFFF5AFF);
        check("flush_mask", 32'(oMask), 32'h2);
        check("flush_vld", 32'(oVld), 32'd1);
        idle(1);
        // sole out-of-range flush: error pulse, no word
        beat(3'd6, 8'h77, 1, 1);
        check("eflush_err", 32'(oErr), 32'd1);
        check("eflush_novld", 32'(oVld), 32'd0);
        idle(1);
        check("err_not_sticky", 32'(oErr), 32'd0);
        // out-of-range write mid-word leaves mask alone
        beat(3'd0, 8'h10, 0, 1);
        beat(3'd6, 8'h66, 0, 1);
        check("oor_err", 32'(oErr), 32'd1);
        check("oor_mask", 32'(oMask), 32'h1);
        idle(1);
        beat(3'd1, 8'h20, 0, 1); beat(3'd2, 8'h30, 0, 1); beat(3'd3, 8'h40, 0, 0);
        check("oor_word", oDat, 32'h40302010);
        idle(1);
        // overwrite wins
        beat(3'd0, 8'h01, 0, 0); beat(3'd0, 8'h02, 0, 0);
        beat(3'd1, 8'hFF, 0, 0); beat(3'd2, 8'hFF, 0, 0); beat(3'd3, 8'hFF, 0, 0);
        check("ovw_dat", oDat, 32'hFFFFFF02);
        check("ovw_noerr", 32'(oErr), 32'd0);
        idle(1);
        // reset in HOLD and mid-word
        beat(3'd0, 8'h01, 0, 0); beat(3'd1, 8'h02, 0, 0); beat(3'd2, 8'h03, 0, 0); beat(3'd3, 8'h04, 0, 0);
        step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        check("rst_hold_vld", 32'(oVld), 32'd0);
        check("rst_hold_dat", oDat, 32'hFFFFFFFF);
        beat(3'd0, 8'hB0, 0, 0); beat(3'd1, 8'hB1, 0, 0);
        step(1'b1, 3'd2, 8'hB2, 1'b0, 1'b0, 1'b1);
        check("rst_part_mask", 32'(oMask), 32'd0);
        check("rst_part_dat", oDat, 32'hFFFFFFFF);
        beat(3'd3, 8'hC3, 0, 1); beat(3'd2, 8'hC2, 0, 1); beat(3'd1, 8'hC1, 0, 1); beat(3'd0, 8'hC0, 0, 1);
        check("fresh_dat", oDat, 32'hC3C2C1C0);
        idle(1);
        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
